led_event_arbiter: RTL and testbench

Shares one indicator LED among N_CH sequence-detector instances. Each detector's match output is a requester. Rising edges are latched as pending events and granted round-robin. Each grant lights the LED for a fixed ON window, followed by a mandatory dark GAP window, so every detected event is visible as a distinct blink. The block sits between the detector bank and the board LED pin.

---
 rtl/led_event_arbiter_pkg.sv | 29 ++
 rtl/led_hold_timer.sv | 33 +++
 rtl/led_event_arbiter.sv | 162 ++++++++++++++++
 tb/tb_led_event_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_event_arbiter_pkg
// Description : Shared types and constants for the LED event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package led_event_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int c_DEF_ON_CYCLES  = 8;
    localparam int c_DEF_GAP_CYCLES = 4;

    // Ceiling log2, never below 1 so a vector built from it always has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_hold_timer
// Description : Loadable down-counter with zero flag; holds at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module led_hold_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/led_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_event_arbiter
// Description : Latches rising edges from N_CH detectors and blinks one LED
//               per event, round-robin, with an ON window and a dark GAP.
// Revision    : 1.0 - initial release
// ============================================================================
module led_event_arbiter
    import led_event_arbiter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ON_CYCLES  = c_DEF_ON_CYCLES,
    parameter int GAP_CYCLES = c_DEF_GAP_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        match,
    input  logic                   enable,
    input  logic                   clr_ovf,
    output logic                   led,
    output logic                   busy,
    output logic [clog2(N_CH)-1:0] active_ch,
    output logic [N_CH-1:0]        pending,
    output logic [N_CH-1:0]        overflow
);

    localparam int c_CH_W    = clog2(N_CH);
    localparam int c_TMAX    = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int c_TIMER_W = clog2(c_TMAX + 1);
    localparam logic [c_TIMER_W-1:0] c_ON_LOAD  = c_TIMER_W'(ON_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LOAD = c_TIMER_W'(GAP_CYCLES - 1);
    localparam logic [c_CH_W:0]      c_N_CH_EXT = (c_CH_W + 1)'(N_CH);

    state_t                r_state;
    logic [N_CH-1:0]       r_match_q;
    logic [N_CH-1:0]       r_pending;
    logic [N_CH-1:0]       r_overflow;
    logic [c_CH_W-1:0]     r_ptr;
    logic [c_CH_W-1:0]     r_active_ch;
    logic                  r_led;
    logic                  r_busy;

    logic [N_CH-1:0]       w_event;
    logic                  w_grant_found;
    logic [c_CH_W-1:0]     w_grant_idx;
    logic [c_CH_W:0]       w_scan;
    logic                  w_do_grant;
    logic [N_CH-1:0]       w_grant_mask;
    logic [c_CH_W-1:0]     w_next_ptr;
    logic                  w_tmr_load;
    logic [c_TIMER_W-1:0]  w_tmr_val;
    logic                  w_tmr_dec;
    logic                  w_tmr_zero;

    assign w_event = match & ~r_match_q;

    // First pending channel scanning ptr, ptr+1, ... with wrap modulo N_CH.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_scan = {1'b0, r_ptr} + (c_CH_W + 1)'(k);
            if (w_scan >= c_N_CH_EXT) begin
                w_scan = w_scan - c_N_CH_EXT;
            end
            if (!w_grant_found && r_pending[w_scan[c_CH_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[c_CH_W-1:0];
            end
        end
    end

    assign w_do_grant   = (r_state == ST_IDLE) && enable && w_grant_found;
    assign w_grant_mask = w_do_grant ? (N_CH'(1) << w_grant_idx) : '0;
    assign w_next_ptr   = (w_grant_idx == c_CH_W'(N_CH - 1)) ? '0
                                                             : w_grant_idx + c_CH_W'(1);

    assign w_tmr_load = w_do_grant || ((r_state == ST_ON) && w_tmr_zero);
    assign w_tmr_val  = w_do_grant ? c_ON_LOAD : c_GAP_LOAD;
    assign w_tmr_dec  = ((r_state == ST_ON) || (r_state == ST_GAP)) && !w_tmr_zero;

    led_hold_timer #(
        .WIDTH (c_TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // A new event in the grant cycle re-arms pending (set beats clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match_q  <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_match_q  <= match;
            r_pending  <= (r_pending & ~w_grant_mask) | w_event;
            r_overflow <= (clr_ovf ? '0 : r_overflow)
                        | (w_event & r_pending & ~w_grant_mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_active_ch <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_led  <= 1'b0;
                    r_busy <= 1'b0;
                    if (w_do_grant) begin
                        r_state     <= ST_ON;
                        r_led       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_active_ch <= w_grant_idx;
                        r_ptr       <= w_next_ptr;
                    end
                end
                ST_ON: begin
                    r_busy <= 1'b1;
                    if (w_tmr_zero) begin
                        r_led   <= 1'b0;
                        r_state <= ST_GAP;
                    end else begin
                        r_led <= 1'b1;
                    end
                end
                ST_GAP: begin
                    r_led <= 1'b0;
                    if (w_tmr_zero) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign led       = r_led;
    assign busy      = r_busy;
    assign active_ch = r_active_ch;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_led_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_event_arbiter
// Description : Directed self-checking bench for led_event_arbiter (4 ch, 8/4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] match;
    logic       enable;
    logic       clr_ovf;
    logic       led;
    logic       busy;
    logic [1:0] active_ch;
    logic [3:0] pending;
    logic [3:0] overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    led_event_arbiter #(
        .N_CH       (4),
        .ON_CYCLES  (8),
        .GAP_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .match     (match),
        .enable    (enable),
        .clr_ovf   (clr_ovf),
        .led       (led),
        .busy      (busy),
        .active_ch (active_ch),
        .pending   (pending),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_blinks(input int n, output int rises, output int highs);
        logic prev;
        rises = 0;
        highs = 0;
        prev  = led;
        for (int i = 0; i < n; i++) begin
            tick();
            if (led === 1'b1) highs++;
            if (led === 1'b1 && prev === 1'b0) rises++;
            prev = led;
        end
    endtask

    task automatic wait_rise(input string tag, input int budget);
        logic prev;
        bit   found;
        prev  = led;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (led === 1'b1 && prev === 1'b0) found = 1'b1;
            prev = led;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        match   = 4'b0000;
        enable  = 1'b1;
        clr_ovf = 1'b0;
        tick_n(2);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int rises;
        int highs;

        // Reset values
        rst = 1'b0; match = 4'b0000; enable = 1'b1; clr_ovf = 1'b0;
        #1;
        check("rst_led",      32'(led),       32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_active",   32'(active_ch), 32'd0);
        check("rst_pending",  32'(pending),   32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        tick_n(2);
        rst = 1'b1;
        tick();

        // Single ch2 event: latency, ON width, busy width
        match = 4'b0100;
        tick();
        check("s1_pending_set", 32'(pending), 32'h4);
        check("s1_led_lat",     32'(led),     32'd0);
        tick();
        check("s1_led_on",      32'(led),       32'd1);
        check("s1_active",      32'(active_ch), 32'd2);
        check("s1_pending_clr", 32'(pending),   32'd0);
        check("s1_busy_on",     32'(busy),      32'd1);
        highs = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (led === 1'b1) highs++;
        end
        check("s1_on_width", 32'(highs), 32'd8);
        tick();
        check("s1_led_off", 32'(led),  32'd0);
        check("s1_gap_busy", 32'(busy), 32'd1);
        tick_n(3);
        check("s1_busy_last", 32'(busy), 32'd1);
        tick();
        check("s1_busy_done", 32'(busy), 32'd0);
        match = 4'b0000;

        // Simultaneous ch0 and ch3 with ptr=0
        do_reset();
        match = 4'b1001;
        tick();
        check("s2_pending", 32'(pending), 32'h9);
        tick();
        check("s2_led0",     32'(led),       32'd1);
        check("s2_active0",  32'(active_ch), 32'd0);
        check("s2_pend_ch3", 32'(pending),   32'h8);
        match = 4'b0000;
        tick_n(12);
        check("s2_idle_led", 32'(led),  32'd0);
        check("s2_idle_busy", 32'(busy), 32'd0);
        tick();
        check("s2_led3",    32'(led),       32'd1);
        check("s2_active3", 32'(active_ch), 32'd3);
        check("s2_pend0",   32'(pending),   32'd0);
        check("s2_ovf",     32'(overflow),  32'd0);

        // Fairness: ch1 served, then ch0+ch1 while busy -> ch0 then ch1
        do_reset();
        match = 4'b0010;
        tick_n(2);
        check("s3_first_ch1", 32'(active_ch), 32'd1);
        match = 4'b0000;
        tick();
        match = 4'b0011;
        tick();
        check("s3_pending", 32'(pending), 32'h3);
        match = 4'b0000;
        wait_rise("s3_rise_a", 40);
        check("s3_order_a", 32'(active_ch), 32'd0);
        wait_rise("s3_rise_b", 40);
        check("s3_order_b", 32'(active_ch), 32'd1);

        // Overflow with enable=0, clear, then one blink
        do_reset();
        enable = 1'b0;
        match = 4'b0010; tick();
        match = 4'b0000; tick();
        match = 4'b0010; tick();
        check("s4_ovf_first", 32'(overflow), 32'h2);
        match = 4'b0000; tick();
        match = 4'b0010; tick();
        match = 4'b0000; tick();
        check("s4_ovf",     32'(overflow), 32'h2);
        check("s4_pending", 32'(pending),  32'h2);
        check("s4_led",     32'(led),      32'd0);
        clr_ovf = 1'b1; tick();
        clr_ovf = 1'b0;
        check("s4_ovf_clr", 32'(overflow), 32'd0);
        enable = 1'b1;
        count_blinks(40, rises, highs);
        check("s4_one_blink", 32'(rises),     32'd1);
        check("s4_blink_len", 32'(highs),     32'd8);
        check("s4_active",    32'(active_ch), 32'd1);
        check("s4_pend_end",  32'(pending),   32'd0);

        // Enable gating, then async reset during ON
        do_reset();
        enable = 1'b0;
        match = 4'b1000; tick();
        match = 4'b0000;
        count_blinks(20, rises, highs);
        check("s5_gated_led", 32'(highs),   32'd0);
        check("s5_gated_pend", 32'(pending), 32'h8);
        enable = 1'b1;
        tick();
        check("s5_en_led",    32'(led),       32'd1);
        check("s5_en_active", 32'(active_ch), 32'd3);
        match = 4'b0010; tick();
        match = 4'b0000; tick();
        match = 4'b0010; tick();
        check("s5_pre_ovf", 32'(overflow), 32'h2);
        check("s5_pre_led", 32'(led),      32'd1);
        match = 4'b0000;
        #2 rst = 1'b0;
        #1;
        check("s5_rst_led",  32'(led),      32'd0);
        check("s5_rst_busy", 32'(busy),     32'd0);
        check("s5_rst_pend", 32'(pending),  32'd0);
        check("s5_rst_ovf",  32'(overflow), 32'd0);
        tick();
        rst = 1'b1;
        count_blinks(30, rises, highs);
        check("s5_no_blink", 32'(highs), 32'd0);
        match = 4'b0001;
        wait_rise("s5_new_rise", 10);
        check("s5_new_active", 32'(active_ch), 32'd0);
        match = 4'b0000;

        // Held level yields a single event
        do_reset();
        match = 4'b0001;
        count_blinks(30, rises, highs);
        check("s6_held_rises", 32'(rises), 32'd1);
        match = 4'b0000;
        count_blinks(20, rises, highs);
        check("s6_after_rises", 32'(rises),    32'd0);
        check("s6_ovf",         32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
